pll_step_sequencer: RTL and testbench
=====================================

# pll_step_sequencer

Single-counter step scheduler for the three-phase PLL control datapath. On each accepted simulation-step request it issues the PLL start pulse and every downstream strobe at fixed cycle offsets from one shared counter:
- PI stage 1 read and start;
- sin/cos FIFO read;
- PI stage 2 read;
- step done.

It replaces the per-strobe delay-line chains and adds busy and overrun reporting. It sits between the system time-step generator and the PLL datapath.

## Interface
Parameters:
- CNT_W, 8, counter width; must satisfy 2^CNT_W > T_DONE
- T_RD_PI1, 16, offset of PI1 input-read strobe
- T_RD_FIFO, 17, offset of sin/cos FIFO read strobe
- T_STA_PI1, 31, offset of PI1 start strobe
- T_RD_PI2, 46, offset of PI2 input-read strobe
- T_DONE, 128, offset of step-done strobe; must exceed every other offset

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rst_user  in  1  synchronous user clear, active-high
- step_req  in  1  one-cycle step request
- sta  out  1  PLL datapath start pulse
- rd_pi1_x  out  1  PI1 input-read strobe
- rd_fifo  out  1  sin/cos FIFO read strobe
- sta_pi1  out  1  PI1 start strobe
- rd_pi2_x  out  1  PI2 input-read strobe
- done_sig  out  1  step-complete strobe
- busy  out  1  step in progress
- overrun  out  1  sticky: a request was dropped
- step_count  out  16  completed steps, wraps at 0xFFFF→0

## Operation
- States:
  - IDLE: counter held at 0, all strobes low, busy=0.
  - RUN: counter increments by 1 each cycle.
- IDLE→RUN:
  - Entered when step_req=1.
  - sta is registered high in the first RUN cycle, with cnt=0.
- Strobe rule: each strobe Y is high for exactly one cycle, the cycle where cnt==T_Y. This equals a T_Y-cycle delay of sta. Strobes are registered outputs.
- RUN→IDLE:
  - Taken in the cycle done_sig is high (cnt==T_DONE).
  - step_count increments in that same cycle.
- Back-to-back requests:
  - A step_req in the done_sig cycle is accepted.
  - sta follows on the next cycle, so the minimum step period is T_DONE+1 cycles.
- Overrun:
  - step_req in RUN at any cnt<T_DONE is dropped.
  - overrun is set and stays set until rst or rst_user.
  - The running step is unaffected.
- rst_user:
  - Next cycle: state=IDLE, cnt=0, all strobes low, overrun=0, step_count=0.
  - A step_req in the same cycle is ignored.
- Mid-step reset: rst or rst_user during RUN aborts the step. No later strobes of that step appear.

## Timing
- Reset values: every output is 0; state=IDLE.
- Latency, measured from the step_req sampling edge (cycle 0):
  - sta at cycle 1
  - rd_pi1_x at 1+T_RD_PI1
  - rd_fifo at 1+T_RD_FIFO
  - sta_pi1 at 1+T_STA_PI1
  - rd_pi2_x at 1+T_RD_PI2
  - done_sig at 1+T_DONE
- busy is high from cycle 1 through cycle 1+T_DONE inclusive.
- Counter width: cnt is CNT_W bits. It never wraps, because a step ends at T_DONE < 2^CNT_W.
- Offset collision: offsets equal to each other assert their strobes in the same cycle. This is legal.

## Structure
- Shared package pll_seq_pkg holds:
  - default offset constants (16, 17, 31, 46, 128);
  - CNT_W;
  - the state enum {IDLE, RUN}.
- One sub-module, seq_strobe_tap: a registered comparator (cnt==T → 1-cycle pulse) with parameter T. It is instantiated once per strobe.
- All other logic is inline: FSM, counter, overrun flag, step counter.

## Test plan
- Single step: step_req at cycle 0 → sta@1, rd_pi1_x@17, rd_fifo@18, sta_pi1@32, rd_pi2_x@47, done_sig@129; each exactly 1 cycle wide; step_count=1; busy high cycles 1–129.
- Back-to-back: step_req at 0 and 129 → second sta@130, second done_sig@258; overrun stays 0; step_count=2.
- Overrun: step_req at 0 and 60 → first step's strobes unchanged; no second sta; overrun=1 from cycle 61 until cleared.
- Mid-step reset: rst low at cycle 40 → all outputs 0 immediately; no rd_pi2_x@47; after release, step_req → normal sequence from sta.
- rst_user: with overrun=1 and step_count=5, pulse rst_user in cycle k → cycle k+1: overrun=0, step_count=0, busy=0.
- Wrap: preload 65535 completed steps, run one more → step_count reads 0.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared constants and state type for the PLL step sequencer.
// Default strobe offsets are measured in cycles from the start pulse.
package pll_seq_pkg;

  localparam int unsigned PLL_CNT_W     = 8;
  localparam int unsigned PLL_T_RD_PI1  = 16;
  localparam int unsigned PLL_T_RD_FIFO = 17;
  localparam int unsigned PLL_T_STA_PI1 = 31;
  localparam int unsigned PLL_T_RD_PI2  = 46;
  localparam int unsigned PLL_T_DONE    = 128;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/seq_strobe_tap.sv
// Registered single-cycle strobe.
// It compares the counter's next value so the pulse lands in the cycle where cnt == T.
module seq_strobe_tap
  import pll_seq_pkg::*;
#(
  parameter int unsigned CNT_W = PLL_CNT_W,
  parameter int unsigned T     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt_nxt,
  output logic             strobe
);

  localparam logic [CNT_W-1:0] T_CNT = CNT_W'(T);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) strobe <= 1'b0;
    else      strobe <= en && (cnt_nxt == T_CNT);
  end

endmodule

// File: rtl/pll_step_sequencer.sv
// Single-counter step scheduler for the PLL control datapath.
// It issues the start pulse and all downstream strobes at fixed offsets, with busy and overrun reporting.
module pll_step_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned CNT_W     = PLL_CNT_W,
  parameter int unsigned T_RD_PI1  = PLL_T_RD_PI1,
  parameter int unsigned T_RD_FIFO = PLL_T_RD_FIFO,
  parameter int unsigned T_STA_PI1 = PLL_T_STA_PI1,
  parameter int unsigned T_RD_PI2  = PLL_T_RD_PI2,
  parameter int unsigned T_DONE    = PLL_T_DONE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rst_user,
  input  logic        step_req,
  output logic        sta,
  output logic        rd_pi1_x,
  output logic        rd_fifo,
  output logic        sta_pi1,
  output logic        rd_pi2_x,
  output logic        done_sig,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] step_count
);

  localparam logic [CNT_W-1:0] T_DONE_CNT = CNT_W'(T_DONE);

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovr_set;
  logic             run_nxt;
  logic             done_nxt;
  logic             overrun_q;
  logic [15:0]      step_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A request in the done cycle restarts at cnt=0 instead of returning to IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ovr_set   = 1'b0;
    if (rst_user) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (step_req) state_nxt = RUN;
        end
        RUN: begin
          if (cnt == T_DONE_CNT) begin
            cnt_nxt   = '0;
            state_nxt = step_req ? RUN : IDLE;
          end else begin
            cnt_nxt = cnt + 1'b1;
            ovr_set = step_req;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign run_nxt  = (state_nxt == RUN);
  assign done_nxt = run_nxt && (cnt_nxt == T_DONE_CNT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q  <= 1'b0;
      step_cnt_q <= '0;
    end else if (rst_user) begin
      overrun_q  <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      if (ovr_set)  overrun_q  <= 1'b1;
      if (done_nxt) step_cnt_q <= step_cnt_q + 16'd1;
    end
  end

  assign busy       = (state == RUN);
  assign overrun    = overrun_q;
  assign step_count = step_cnt_q;

  seq_strobe_tap #(.CNT_W(CNT_W), .T(0)) u_tap_sta (
    .clk(clk), .rst(rst), .en(run_nxt), .cnt_nxt(cnt_nxt), .strobe(sta)
  );
  seq_strobe_tap #(.CNT_W(CNT_W), .T(T_RD_PI1)) u_tap_rd_pi1 (
    .clk(clk), .rst(rst), .en(run_nxt), .cnt_nxt(cnt_nxt), .strobe(rd_pi1_x)
  );
  seq_strobe_tap #(.CNT_W(CNT_W), .T(T_RD_FIFO)) u_tap_rd_fifo (
    .clk(clk), .rst(rst), .en(run_nxt), .cnt_nxt(cnt_nxt), .strobe(rd_fifo)
  );
  seq_strobe_tap #(.CNT_W(CNT_W), .T(T_STA_PI1)) u_tap_sta_pi1 (
    .clk(clk), .rst(rst), .en(run_nxt), .cnt_nxt(cnt_nxt), .strobe(sta_pi1)
  );
  seq_strobe_tap #(.CNT_W(CNT_W), .T(T_RD_PI2)) u_tap_rd_pi2 (
    .clk(clk), .rst(rst), .en(run_nxt), .cnt_nxt(cnt_nxt), .strobe(rd_pi2_x)
  );
  seq_strobe_tap #(.CNT_W(CNT_W), .T(T_DONE)) u_tap_done (
    .clk(clk), .rst(rst), .en(run_nxt), .cnt_nxt(cnt_nxt), .strobe(done_sig)
  );

endmodule

// File: tb/tb_pll_step_sequencer.sv
// Directed bench for pll_step_sequencer with default offsets.
// Cycle c=1 is the first cycle after the edge that samples step_req.
module tb_pll_step_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst_user = 1'b0;
  logic        step_req = 1'b0;
  logic        sta, rd_pi1_x, rd_fifo, sta_pi1, rd_pi2_x, done_sig, busy, overrun;
  logic [15:0] step_count;

  int checks = 0;
  int failures = 0;

  pll_step_sequencer #(
    .CNT_W(8), .T_RD_PI1(16), .T_RD_FIFO(17), .T_STA_PI1(31), .T_RD_PI2(46), .T_DONE(128)
  ) dut (
    .clk(clk), .rst(rst), .rst_user(rst_user), .step_req(step_req),
    .sta(sta), .rd_pi1_x(rd_pi1_x), .rd_fifo(rd_fifo), .sta_pi1(sta_pi1),
    .rd_pi2_x(rd_pi2_x), .done_sig(done_sig), .busy(busy), .overrun(overrun),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {sta, rd_pi1_x, rd_fifo, sta_pi1, rd_pi2_x, done_sig, busy}
  function automatic logic [6:0] exp_vec(input int c);
    exp_vec = {c == 1, c == 17, c == 18, c == 32, c == 47, c == 129, (c >= 1 && c <= 129)};
  endfunction

  function automatic logic [6:0] obs_vec();
    obs_vec = {sta, rd_pi1_x, rd_fifo, sta_pi1, rd_pi2_x, done_sig, busy};
  endfunction

  // Plain step with an optional extra request at cycle extra_at (0 = none).
  task automatic run_step(input int extra_at);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int c = 1; c <= 131; c++) begin
      step_req = (c == extra_at);
      tick();
    end
    step_req = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("reset_strobes", 32'(obs_vec()), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_count", 32'(step_count), 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_after_reset", 32'(obs_vec()), 32'd0);

    // Single step
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int c = 1; c <= 131; c++) begin
      chk($sformatf("single_c%0d", c), 32'(obs_vec()), 32'(exp_vec(c)));
      tick();
    end
    chk("single_count", 32'(step_count), 32'd1);
    chk("single_overrun", 32'(overrun), 32'd0);

    // Back-to-back: second request in the done cycle
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int c = 1; c <= 129; c++) begin
      chk($sformatf("b2b_a_c%0d", c), 32'(obs_vec()), 32'(exp_vec(c)));
      step_req = (c == 129);
      tick();
    end
    step_req = 1'b0;
    for (int c = 1; c <= 131; c++) begin
      chk($sformatf("b2b_b_c%0d", c), 32'(obs_vec()), 32'(exp_vec(c)));
      tick();
    end
    chk("b2b_overrun", 32'(overrun), 32'd0);
    chk("b2b_count", 32'(step_count), 32'd3);

    // Overrun: request at cycle 60 is dropped
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int c = 1; c <= 131; c++) begin
      chk($sformatf("ovr_c%0d", c), 32'(obs_vec()), 32'(exp_vec(c)));
      chk($sformatf("ovr_flag_c%0d", c), 32'(overrun), 32'(c >= 61));
      step_req = (c == 60);
      tick();
    end
    chk("ovr_count", 32'(step_count), 32'd4);

    // Mid-step asynchronous reset at cycle 40
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int c = 1; c < 40; c++) tick();
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_strobes", 32'(obs_vec()), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    chk("midrst_count", 32'(step_count), 32'd0);
    for (int c = 41; c <= 44; c++) tick();
    rst = 1'b1;
    for (int c = 45; c <= 50; c++) begin
      chk($sformatf("midrst_quiet_c%0d", c), 32'(obs_vec()), 32'd0);
      tick();
    end
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int c = 1; c <= 131; c++) begin
      chk($sformatf("postrst_c%0d", c), 32'(obs_vec()), 32'(exp_vec(c)));
      tick();
    end
    chk("postrst_count", 32'(step_count), 32'd1);

    // Build overrun=1, step_count=5, then rst_user with a simultaneous request
    run_step(0);
    run_step(90);
    run_step(0);
    run_step(0);
    chk("pre_user_overrun", 32'(overrun), 32'd1);
    chk("pre_user_count", 32'(step_count), 32'd5);
    rst_user = 1'b1;
    step_req = 1'b1;
    tick();
    rst_user = 1'b0;
    step_req = 1'b0;
    chk("user_overrun", 32'(overrun), 32'd0);
    chk("user_count", 32'(step_count), 32'd0);
    chk("user_busy", 32'(busy), 32'd0);
    chk("user_strobes", 32'(obs_vec()), 32'd0);
    tick();
    chk("user_req_ignored", 32'(obs_vec()), 32'd0);

    // rst_user mid-step aborts it
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    rst_user = 1'b1;
    tick();
    rst_user = 1'b0;
    for (int c = 21; c <= 50; c++) begin
      chk($sformatf("user_abort_c%0d", c), 32'(obs_vec()), 32'd0);
      tick();
    end

    // Step counter wrap
    dut.step_cnt_q = 16'hFFFF;
    tick();
    chk("wrap_preload", 32'(step_count), 32'h0000FFFF);
    run_step(0);
    chk("wrap_count", 32'(step_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
